rtc_time_editor: RTL
====================

# rtc_time_editor

User-edit front end for the RTC controller stage (ControlRTC). Decodes the mode switches (`interruptores`) and push buttons (`selectores`) into a BCD edit session. On entry it reads the three fields of the selected group from the controller into shadow registers. Up/down/left/right then edit the shadows with per-field BCD wrap. On exit it commits the three fields back through a request/acknowledge handshake, driving the controller's `ADDreadreg` and `writedata` inputs.

## Interface
- `RD_WAIT`, default 8: cycles from `ADDreadreg` change to `datamemoria` capture (1..255).
- `WR_TIMEOUT`, default 255: max cycles to wait for `wr_ack` per field (1..255).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `interruptores`  in  3  mode: `001` time, `010` date, `100` timer; any other value = no edit.
- `selectores`  in  4  raw buttons {right,left,down,up}, asynchronous levels.
- `datamemoria`  in  8  BCD read data from controller for current `ADDreadreg`.
- `wr_ack`  in  1  controller accepted current write (level, sampled each cycle).
- `ADDreadreg`  out  4  field index: 0-2 time sec/min/hour, 3-5 date day/month/year, 6-8 timer sec/min/hour.
- `writedata`  out  8  BCD value to write.
- `wr_req`  out  1  write request.
- `busy`  out  1  high in LOAD or COMMIT.
- `editing`  out  1  high in EDIT.
- `cursor`  out  2  selected field 0..2 (sec/day, min/month, hour/year), for display blink.
- `err`  out  1  sticky write timeout flag.

## Operation
- States: IDLE, LOAD, EDIT, COMMIT.
- IDLE: if `interruptores` is one-hot, latch group G (0/1/2), set cursor=0, go LOAD.
- LOAD: for k=0..2 drive `ADDreadreg`=3G+k, wait RD_WAIT cycles, capture `datamemoria` into shadow[k].
  - Clear `err` on LOAD entry.
  - Sanitize on capture: any nibble >9 or value outside field range → field minimum.
  - After k=2, go EDIT.
- Field ranges (BCD):
  - sec/min: 00-59
  - hour: 00-23
  - day: 01-31
  - month: 01-12
  - year: 00-99
- EDIT, one action per detected button rising edge:
  - up: +1; max wraps to min.
  - down: −1; min wraps to max.
  - left: cursor−1; 0 wraps to 2.
  - right: cursor+1; 2 wraps to 0.
- Simultaneous edges in the same cycle: only the highest priority is executed (up > down > left > right); the others are discarded.
- EDIT exit: `interruptores` differs from the latched mode (including a direct switch to another one-hot mode) → COMMIT with the old G. If the new value is one-hot, go LOAD of the new group after COMMIT; else go IDLE.
- COMMIT: for k=0..2 drive `ADDreadreg`=3G+k and `writedata`=shadow[k], assert `wr_req`.
  - Per field: wait for `wr_ack` or WR_TIMEOUT cycles. On timeout set `err` and continue with the next field.
- Buttons are ignored outside EDIT. Mode changes during LOAD/COMMIT are not acted on until the current LOAD/COMMIT finishes.
- Reset (any state, including mid-COMMIT): immediate IDLE; no further `wr_req`.

## Timing
- Reset values: `ADDreadreg`=0, `writedata`=0x00, `wr_req`=0, `busy`=0, `editing`=0, `cursor`=0, `err`=0; shadows 0x00; synchronizers 0.
- Buttons: 2-flop synchronizer + edge register. Shadow/cursor update 3 cycles after the input rises. A held button produces one action.
- `interruptores` is synchronized with 2 flops. IDLE→LOAD 1 cycle after the synchronized mode is valid.
- LOAD: `ADDreadreg` registered. Capture on the RD_WAIT-th cycle after it changes. EDIT entered 3·RD_WAIT+1 cycles after LOAD entry.
- Handshake:
  - `wr_req` and `writedata` are stable while `wr_req`=1.
  - `wr_ack` sampled high → `wr_req` low the next cycle; next field's `wr_req` rises one cycle after that (≥1 idle cycle between requests).
  - `wr_ack` already high when `wr_req` rises is accepted in that cycle.
- `busy` is registered and asserts in the first LOAD/COMMIT cycle. `editing` asserts on the first EDIT cycle.

## Test plan
- Reset release with `interruptores`=000 → all outputs at reset values, `wr_req` never asserts over 1000 cycles.
- Mode 001, `datamemoria` returns 0x59/0x59/0x23 for indices 0/1/2 → one up on each field (right between) → commit writes 0x00, 0x00, 0x00 to indices 0,1,2 in order after mode 000.
- Mode 010, loads 0x01/0x01/0x00 → down on field 0 gives 0x31, right+down gives 0x12, right+down gives 0x99; left from cursor 0 gives cursor 2.
- Load of invalid 0x7A for minutes → shadow 0x00; up+down pressed same cycle → only up applied (0x01).
- `wr_ack` tied low, WR_TIMEOUT=4 → each field's `wr_req` held 4 cycles, `err`=1, IDLE reached; `err` clears on next LOAD.
- Switch 001→100 directly in EDIT → time COMMIT (indices 0-2), then LOAD of indices 6-8. Reset asserted mid-COMMIT → `wr_req` drops asynchronously, IDLE.

Source files
------------

// File: rtl/rtc_time_editor.sv
// BCD edit front end for the RTC controller: loads a field group into shadow
// registers, edits it from push buttons and writes it back with a req/ack handshake.
//
// state  | meaning
// IDLE   | no edit session, waiting for a one-hot mode
// LOAD   | reading the three fields of the group into the shadows
// EDIT   | buttons edit the shadows, mode change ends the session
// COMMIT | writing the three shadows back, one handshake per field
module rtc_time_editor #(
    parameter int unsigned RD_WAIT    = 8,
    parameter int unsigned WR_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [2:0] interruptores_i,
    input  logic [3:0] selectores_i,
    input  logic [7:0] datamemoria_i,
    input  logic       wr_ack_i,
    output logic [3:0] ADDreadreg_o,
    output logic [7:0] writedata_o,
    output logic       wr_req_o,
    output logic       busy_o,
    output logic       editing_o,
    output logic [1:0] cursor_o,
    output logic       err_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EDIT, S_COMMIT} state_e;

    localparam logic [7:0] RD_RELOAD = 8'(RD_WAIT - 1);
    localparam logic [7:0] WR_RELOAD = 8'(WR_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [2:0] mode_s1_q, mode_s2_q;
    logic [3:0] sel_s1_q, sel_s2_q, sel_prev_q;
    logic [2:0] mode_q, mode_d;
    logic [1:0] grp_q, grp_d;
    logic [1:0] k_q, k_d;
    logic [7:0] cnt_q, cnt_d;
    logic       arm_q, arm_d;
    logic [7:0] shadow_q [3];
    logic [7:0] shadow_d [3];
    logic [1:0] cursor_q, cursor_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wr_req_q, wr_req_d;
    logic       busy_q, busy_d;
    logic       editing_q, editing_d;
    logic       err_q, err_d;
    logic [3:0] sel_rise;
    logic [7:0] cur_v, cur_mn, cur_mx;

    function automatic logic onehot3(input logic [2:0] m);
        return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
    endfunction

    function automatic logic [1:0] grp_of(input logic [2:0] m);
        case (m)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] fld_addr(input logic [1:0] g, input logic [1:0] k);
        return ({2'b00, g} << 1) + {2'b00, g} + {2'b00, k};
    endfunction

    function automatic logic [7:0] fld_min(input logic [1:0] g, input logic [1:0] k);
        return (g == 2'd1 && k != 2'd2) ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [7:0] fld_max(input logic [1:0] g, input logic [1:0] k);
        if (g == 2'd1) begin
            case (k)
                2'd0:    return 8'h31;
                2'd1:    return 8'h12;
                default: return 8'h99;
            endcase
        end
        return (k == 2'd2) ? 8'h23 : 8'h59;
    endfunction

    function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [7:0] mn,
                                            input logic [7:0] mx);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v < mn || v > mx) return mn;
        return v;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mn,
                                           input logic [7:0] mx);
        if (v == mx) return mn;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mn,
                                           input logic [7:0] mx);
        if (v == mn) return mx;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

    assign sel_rise = sel_s2_q & ~sel_prev_q;
    assign cur_v    = shadow_q[cursor_q];
    assign cur_mn   = fld_min(grp_q, cursor_q);
    assign cur_mx   = fld_max(grp_q, cursor_q);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (onehot3(mode_s2_q)) state_d = S_LOAD;
            S_LOAD:   if (!arm_q && cnt_q == 8'd0 && k_q == 2'd2) state_d = S_EDIT;
            S_EDIT:   if (mode_s2_q != mode_q) state_d = S_COMMIT;
            S_COMMIT: if (!wr_req_q && k_q == 2'd2)
                          state_d = onehot3(mode_s2_q) ? S_LOAD : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mode_d    = mode_q;
        grp_d     = grp_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        arm_d     = arm_q;
        shadow_d  = shadow_q;
        cursor_d  = cursor_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_req_d  = wr_req_q;
        err_d     = err_q;
        case (state_q)
            S_LOAD: begin
                if (arm_q) begin
                    addr_d = fld_addr(grp_q, k_q);
                    cnt_d  = RD_RELOAD;
                    arm_d  = 1'b0;
                end else if (cnt_q == 8'd0) begin
                    shadow_d[k_q] = sanitize(datamemoria_i, fld_min(grp_q, k_q),
                                             fld_max(grp_q, k_q));
                    if (k_q != 2'd2) begin
                        k_d    = k_q + 2'd1;
                        addr_d = fld_addr(grp_q, k_q + 2'd1);
                        cnt_d  = RD_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_EDIT: begin
                if (state_d == S_COMMIT) begin
                    k_d      = 2'd0;
                    addr_d   = fld_addr(grp_q, 2'd0);
                    wdata_d  = shadow_q[0];
                    wr_req_d = 1'b1;
                    cnt_d    = WR_RELOAD;
                end else if (sel_rise[0]) begin
                    shadow_d[cursor_q] = bcd_inc(cur_v, cur_mn, cur_mx);
                end else if (sel_rise[1]) begin
                    shadow_d[cursor_q] = bcd_dec(cur_v, cur_mn, cur_mx);
                end else if (sel_rise[2]) begin
                    cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
                end else if (sel_rise[3]) begin
                    cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
                end
            end
            S_COMMIT: begin
                if (wr_req_q) begin
                    if (wr_ack_i) begin
                        wr_req_d = 1'b0;
                    end else if (cnt_q == 8'd0) begin
                        wr_req_d = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else if (k_q != 2'd2) begin
                    // Request drops for one cycle between fields.
                    k_d      = k_q + 2'd1;
                    addr_d   = fld_addr(grp_q, k_q + 2'd1);
                    wdata_d  = shadow_q[k_q + 2'd1];
                    wr_req_d = 1'b1;
                    cnt_d    = WR_RELOAD;
                end
            end
            default: ;
        endcase
        if (state_d == S_LOAD && state_q != S_LOAD) begin
            mode_d   = mode_s2_q;
            grp_d    = grp_of(mode_s2_q);
            k_d      = 2'd0;
            arm_d    = 1'b1;
            cursor_d = 2'd0;
            err_d    = 1'b0;
        end
    end

    always_comb begin
        busy_d    = (state_d == S_LOAD) || (state_d == S_COMMIT);
        editing_d = (state_d == S_EDIT);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mode_s1_q  <= '0;
            mode_s2_q  <= '0;
            sel_s1_q   <= '0;
            sel_s2_q   <= '0;
            sel_prev_q <= '0;
            mode_q     <= '0;
            grp_q      <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            arm_q      <= 1'b0;
            for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
            cursor_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            editing_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mode_s1_q  <= interruptores_i;
            mode_s2_q  <= mode_s1_q;
            sel_s1_q   <= selectores_i;
            sel_s2_q   <= sel_s1_q;
            sel_prev_q <= sel_s2_q;
            mode_q     <= mode_d;
            grp_q      <= grp_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            arm_q      <= arm_d;
            shadow_q   <= shadow_d;
            cursor_q   <= cursor_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_req_q   <= wr_req_d;
            busy_q     <= busy_d;
            editing_q  <= editing_d;
            err_q      <= err_d;
        end
    end

    assign ADDreadreg_o = addr_q;
    assign writedata_o  = wdata_q;
    assign wr_req_o     = wr_req_q;
    assign busy_o       = busy_q;
    assign editing_o    = editing_q;
    assign cursor_o     = cursor_q;
    assign err_o        = err_q;

endmodule
